// File: rtl/lcd_ctrl_pkg.sv
// lcd_ctrl_pkg: shared constants and types for the LCD window controller.
//   - command codes (3-bit)
//   - FSM state enum
//   - image size, window size, origin bounds and origin reset value
package lcd_ctrl_pkg;

  localparam int IMG_SIZE = 8;  // image width/height in pixels
  localparam int WIN_SIZE = 4;  // display window width/height

  localparam logic [2:0] CMD_REFLASH  = 3'd0;
  localparam logic [2:0] CMD_LOAD     = 3'd1;
  localparam logic [2:0] CMD_ZOOM_IN  = 3'd2;
  localparam logic [2:0] CMD_ZOOM_FIT = 3'd3;
  localparam logic [2:0] CMD_RIGHT    = 3'd4;
  localparam logic [2:0] CMD_LEFT     = 3'd5;
  localparam logic [2:0] CMD_UP       = 3'd6;
  localparam logic [2:0] CMD_DOWN     = 3'd7;

  // Zoom origin (X,Y) is the pixel just right/below the window centre;
  // keeping it in 2..6 keeps the 4x4 window X-2..X+1 inside the image.
  localparam logic [2:0] ORG_MIN  = 3'd2;
  localparam logic [2:0] ORG_MAX  = 3'd6;
  localparam logic [2:0] ORG_INIT = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_OUT  = 2'd2
  } lcd_state_e;

endpackage

// File: rtl/lcd_img_mem.sv
// lcd_img_mem: image store, DEPTH x PIX_W register file.
//   clk    : write clock
//   we     : write enable (synchronous write)
//   waddr  : write address
//   wdata  : write data
//   raddr  : read address (combinational read)
//   rdata  : read data
// Contents are deliberately not reset.
module lcd_img_mem #(
  parameter int DEPTH = 64,
  parameter int PIX_W = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [PIX_W-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [PIX_W-1:0] rdata
);

  logic [PIX_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/lcd_ctrl.sv
// lcd_ctrl: 8x8 image store with a 4x4 display window (Fit / Zoom views).
//   clk          : rising-edge clock
//   reset        : asynchronous active-low reset
//   cmd          : command code (see lcd_ctrl_pkg)
//   cmd_valid    : command strobe
//   datain       : pixel data, one per cycle during Load
//   dataout      : display pixel, holds its last value when not valid
//   output_valid : dataout carries a window pixel this cycle
//   busy         : commands are not being accepted
//   state_dbg    : current FSM state, for observation
//
// Handshake: a command transfers on a rising edge where cmd_valid=1 and
// busy=0 (busy acts as an inverted ready); cmd_valid while busy=1 is
// dropped, not queued. Each command then streams 16 pixels on 16
// consecutive cycles with output_valid=1, and busy falls together with
// output_valid, so the next command may transfer on the following edge.
module lcd_ctrl
  import lcd_ctrl_pkg::*;
#(
  parameter int IMG_W = IMG_SIZE,
  parameter int PIX_W = 8,
  parameter int WIN   = WIN_SIZE
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       cmd,
  input  logic             cmd_valid,
  input  logic [PIX_W-1:0] datain,
  output logic [PIX_W-1:0] dataout,
  output logic             output_valid,
  output logic             busy,
  output lcd_state_e       state_dbg
);

  localparam logic [5:0] LOAD_LAST = 6'(IMG_W * IMG_W - 1);
  localparam logic [5:0] OUT_LAST  = 6'(WIN * WIN - 1);

  lcd_state_e       state_q, state_d;
  logic [5:0]       cnt_q, cnt_d;
  logic             fit_q, fit_d;
  logic [2:0]       x_q, x_d, y_q, y_d;
  logic [PIX_W-1:0] dout_q;

  logic [2:0]       rd_row, rd_col;
  logic [PIX_W-1:0] rd_data;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      fit_q   <= 1'b1;
      x_q     <= ORG_INIT;
      y_q     <= ORG_INIT;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fit_q   <= fit_d;
      x_q     <= x_d;
      y_q     <= y_d;
      if (state_q == ST_OUT) dout_q <= rd_data;
    end
  end

  // The view update happens on the accepting edge, so the first output
  // cycle already reads through the new mode/origin.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fit_d   = fit_q;
    x_d     = x_q;
    y_d     = y_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          cnt_d = '0;
          if (cmd == CMD_LOAD) begin
            state_d = ST_LOAD;
            fit_d   = 1'b1;
            x_d     = ORG_INIT;
            y_d     = ORG_INIT;
          end else begin
            state_d = ST_OUT;
            case (cmd)
              CMD_ZOOM_IN: begin
                if (fit_q) begin
                  fit_d = 1'b0;
                  x_d   = ORG_INIT;
                  y_d   = ORG_INIT;
                end
              end
              CMD_ZOOM_FIT: begin
                fit_d = 1'b1;
                x_d   = ORG_INIT;
                y_d   = ORG_INIT;
              end
              CMD_RIGHT: if (!fit_q && x_q < ORG_MAX) x_d = x_q + 3'd1;
              CMD_LEFT:  if (!fit_q && x_q > ORG_MIN) x_d = x_q - 3'd1;
              CMD_UP:    if (!fit_q && y_q > ORG_MIN) y_d = y_q - 3'd1;
              CMD_DOWN:  if (!fit_q && y_q < ORG_MAX) y_d = y_q + 3'd1;
              default: ;
            endcase
          end
        end
      end
      ST_LOAD: begin
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == LOAD_LAST) begin
          state_d = ST_OUT;
          cnt_d   = '0;
        end
      end
      ST_OUT: begin
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == OUT_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Window pixel for output index cnt_q[3:0] (row-major, 4 per row).
  // Fit samples every other pixel; Zoom reads the block around (X,Y).
  always_comb begin
    if (fit_q) begin
      rd_row = {cnt_q[3:2], 1'b0};
      rd_col = {cnt_q[1:0], 1'b0};
    end else begin
      rd_row = y_q + {1'b0, cnt_q[3:2]} - ORG_MIN;
      rd_col = x_q + {1'b0, cnt_q[1:0]} - ORG_MIN;
    end
  end

  lcd_img_mem #(
    .DEPTH (IMG_W * IMG_W),
    .PIX_W (PIX_W)
  ) u_mem (
    .clk   (clk),
    .we    (state_q == ST_LOAD),
    .waddr (cnt_q),
    .wdata (datain),
    .raddr ({rd_row, rd_col}),
    .rdata (rd_data)
  );

  assign output_valid = (state_q == ST_OUT);
  assign busy         = (state_q != ST_IDLE);
  assign dataout      = output_valid ? rd_data : dout_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_lcd_ctrl.sv
// tb_lcd_ctrl: directed bench for lcd_ctrl. Loads pix[i]=i, then walks
// through zoom, shifts (including clamping), fit, reflash, a command
// pulsed while busy, and a reset in the middle of an output burst.
module tb_lcd_ctrl;
  import lcd_ctrl_pkg::*;

  localparam int PIX_W = 8;

  logic             clk;
  logic             reset;
  logic [2:0]       cmd;
  logic             cmd_valid;
  logic [PIX_W-1:0] datain;
  logic [PIX_W-1:0] dataout;
  logic             output_valid;
  logic             busy;
  lcd_state_e       state_dbg;

  logic [PIX_W-1:0] exp_q[$];
  int vectors;
  int miscompares;

  lcd_ctrl #(.IMG_W(8), .PIX_W(PIX_W), .WIN(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .cmd          (cmd),
    .cmd_valid    (cmd_valid),
    .datain       (datain),
    .dataout      (dataout),
    .output_valid (output_valid),
    .busy         (busy),
    .state_dbg    (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // checking
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected 4x4 view from top-left pixel (r0,c0) with sampling step;
  // with pix[i]=i a pixel's value is row*8+col.
  task automatic push_view(input int r0, input int c0, input int step);
    exp_q.delete();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        exp_q.push_back(8'((r0 + r * step) * 8 + c0 + c * step));
  endtask

  // drivers: called at a negedge; the command is taken on the next posedge.
  task automatic send_cmd(input logic [2:0] c);
    cmd       = c;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic load_image();
    send_cmd(CMD_LOAD);
    check("load_busy", busy, 1'b1);
    for (int i = 0; i < 64; i++) begin
      datain = 8'(i);
      if (i == 10) check("load_noval", output_valid, 1'b0);
      if (i != 63) @(negedge clk);
    end
    @(negedge clk);
  endtask

  // Checks n outputs from the current negedge on. If n==16, also checks
  // the drop of valid/busy and that dataout holds. pulse_at>=0 pulses a
  // Zoom-In command during that output cycle (must be ignored).
  task automatic collect(input string tag, input int n, input int pulse_at);
    logic [PIX_W-1:0] e;
    e = '0;
    for (int i = 0; i < n; i++) begin
      e = exp_q.pop_front();
      check({tag, "_valid"}, output_valid, 1'b1);
      check({tag, "_busy"}, busy, 1'b1);
      check({tag, "_data"}, dataout, e);
      if (i == pulse_at) begin
        cmd       = CMD_ZOOM_IN;
        cmd_valid = 1'b1;
      end else begin
        cmd_valid = 1'b0;
      end
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    if (n == 16) begin
      check({tag, "_end_valid"}, output_valid, 1'b0);
      check({tag, "_end_busy"}, busy, 1'b0);
      check({tag, "_hold"}, dataout, e);
      check({tag, "_idle"}, state_dbg, ST_IDLE);
    end
  endtask

  task automatic run(input logic [2:0] c, input string tag, input int r0, input int c0,
                     input int step);
    push_view(r0, c0, step);
    send_cmd(c);
    collect(tag, 16, -1);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b0;
    cmd         = '0;
    cmd_valid   = 1'b0;
    datain      = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_valid", output_valid, 1'b0);
    check("rst_data", dataout, 8'h00);
    check("rst_state", state_dbg, ST_IDLE);
    reset = 1'b1;
    @(negedge clk);

    // Load pix[i]=i: Fit view 00,02,..,36
    push_view(0, 0, 2);
    check("fit_tbl0", exp_q[5], 8'h12);
    load_image();
    collect("load", 16, -1);

    run(CMD_ZOOM_IN, "zoom", 2, 2, 1);          // 12,13,..,2D
    run(CMD_RIGHT, "r1", 2, 3, 1);              // X=5
    run(CMD_RIGHT, "r2", 2, 4, 1);              // X=6
    run(CMD_RIGHT, "r3_clamp", 2, 4, 1);        // first row 14..17
    run(CMD_UP, "u1", 1, 4, 1);                 // Y=3
    run(CMD_UP, "u2", 0, 4, 1);                 // Y=2
    run(CMD_UP, "u3_clamp", 0, 4, 1);
    run(CMD_LEFT, "l1", 0, 3, 1);               // X=5
    run(CMD_DOWN, "d1", 1, 3, 1);               // Y=3
    run(CMD_ZOOM_IN, "zoom_again", 1, 3, 1);    // no change in Zoom
    run(CMD_REFLASH, "refl_zoom", 1, 3, 1);
    run(CMD_ZOOM_FIT, "fit", 0, 0, 2);
    run(CMD_LEFT, "left_fit", 0, 0, 2);
    run(CMD_DOWN, "down_fit", 0, 0, 2);
    run(CMD_REFLASH, "refl_fit", 0, 0, 2);

    // Zoom-In pulsed while busy must be dropped.
    push_view(0, 0, 2);
    send_cmd(CMD_REFLASH);
    collect("busy_pulse", 16, 5);
    run(CMD_REFLASH, "after_pulse", 0, 0, 2);

    // Reset during the 8th output of a Zoom-In burst.
    push_view(2, 2, 1);
    send_cmd(CMD_ZOOM_IN);
    collect("pre_rst", 7, -1);
    check("rst8_valid_pre", output_valid, 1'b1);
    check("rst8_data_pre", dataout, exp_q[0]);
    reset = 1'b0;
    #1;
    check("rst8_valid", output_valid, 1'b0);
    check("rst8_busy", busy, 1'b0);
    check("rst8_data", dataout, 8'h00);
    check("rst8_state", state_dbg, ST_IDLE);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    run(CMD_ZOOM_IN, "post_rst_zoom", 2, 2, 1);
    run(CMD_ZOOM_FIT, "post_rst_fit", 0, 0, 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Safety net against a stuck run.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected end before 200000");
    $fatal(1);
  end

endmodule
